// File: rtl/parity_check_rx.sv
// parity_check_rx: serial-to-parallel frame receiver with a parity check.
// Each frame is DATA_W payload bits, LSB first, followed by one parity bit.
// The assembled payload is presented with a valid/ready handshake.
// Optional feature: define PARITY_ERR_CNT_EN to add the saturating err_cnt port.
module parity_check_rx #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_valid,
    input  logic              ser_data,
    input  logic              ser_start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam int unsigned IDX_W    = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // With a one-bit payload the frame start is also the last payload bit.
    localparam state_e FIRST_STATE = (DATA_W == 1) ? PARITY : SHIFT;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               perr_q, perr_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
`ifdef PARITY_ERR_CNT_EN
    logic [15:0]        err_cnt_q, err_cnt_d;
`endif

    logic start_c;
    logic xfer_c;

    assign start_c = ser_valid && ser_start;
    assign xfer_c  = valid_q && out_ready;

    // Next-state and datapath: frame assembly, parity evaluation, hold/handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        perr_d    = perr_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef PARITY_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_c) begin
                    data_d  = DATA_W'(ser_data);
                    idx_d   = IDX_W'(1);
                    state_d = FIRST_STATE;
                end
            end
            SHIFT: begin
                if (start_c) begin
                    // Restart: the frame in progress is silently discarded.
                    data_d  = DATA_W'(ser_data);
                    idx_d   = IDX_W'(1);
                    state_d = FIRST_STATE;
                end else if (ser_valid) begin
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            data_d[i] = ser_data;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (start_c) begin
                    data_d  = DATA_W'(ser_data);
                    idx_d   = IDX_W'(1);
                    state_d = FIRST_STATE;
                end else if (ser_valid) begin
                    perr_d  = (^data_q) ^ ser_data ^ 1'(PARITY_ODD);
                    valid_d = 1'b1;
                    state_d = HOLD;
`ifdef PARITY_ERR_CNT_EN
                    if (perr_d && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
`endif
                end
            end
            HOLD: begin
                if (xfer_c && start_c) begin
                    // Transfer and next frame start share one cycle (no bubble).
                    valid_d = 1'b0;
                    data_d  = DATA_W'(ser_data);
                    idx_d   = IDX_W'(1);
                    state_d = FIRST_STATE;
                end else begin
                    if (xfer_c) begin
                        valid_d = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                    if (ser_valid) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef PARITY_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_perr  = perr_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
`ifdef PARITY_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: scoreboard bench for parity_check_rx (DATA_W=32, even parity).
module tb_parity_check_rx;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          ser_valid;
    logic          ser_data;
    logic          ser_start;
    logic [DW-1:0] out_data;
    logic          out_perr;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
`ifdef PARITY_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;

    parity_check_rx #(.DATA_W(DW), .PARITY_ODD(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_start (ser_start),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One serial bit on the next rising edge; inputs change 1 time unit after the edge.
    task automatic drive_bit(input logic d, input logic s);
        ser_valid = 1'b1;
        ser_data  = d;
        ser_start = s;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        ser_start = 1'b0;
        ser_data  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full frame; the expected result is pushed before driving.
    task automatic send_frame(input logic [DW-1:0] d, input logic par, input int gap_max);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ par;
        sb_q.push_back(e);
        for (int i = 0; i < DW; i++) begin
            drive_bit(d[i], i == 0);
            if (gap_max > 0) idle_cycles($urandom_range(0, gap_max));
        end
        check("pre_parity_valid", 64'(out_valid), 64'd0);
        drive_bit(par, 1'b0);
        check("latency_valid", 64'(out_valid), 64'd1);
    endtask

    // Scoreboard: a transfer happens on the next rising edge when valid&&ready here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'(out_data), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_perr", 64'(out_perr), 64'(e.perr));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n_before;
        logic [DW-1:0] hold_data;
        rst       = 1'b1;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_start = 1'b0;
        out_ready = 1'b1;
        idle_cycles(3);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_perr", 64'(out_perr), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
`ifdef PARITY_ERR_CNT_EN
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        rst = 1'b0;

        // Good parity, then bad parity on the same payload.
        send_frame(32'hA5A50001, 1'b1, 0);
        idle_cycles(2);
        send_frame(32'hA5A50001, 1'b0, 0);
`ifdef PARITY_ERR_CNT_EN
        check("err_cnt_one", 64'(err_cnt), 64'd1);
`endif
        idle_cycles(2);

        // Stall in HOLD, drop a bit while stalled, then release.
        out_ready = 1'b0;
        hold_data = 32'h12345678;
        send_frame(hold_data, 1'b1, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) drive_bit(1'b1, 1'b0);
            else idle_cycles(1);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(hold_data));
            check("hold_perr", 64'(out_perr), 64'((^hold_data) ^ 1'b1));
        end
        check("overrun_set", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        idle_cycles(2);
        check("after_xfer_valid", 64'(out_valid), 64'd0);
        check("overrun_sticky", 64'(overrun), 64'd1);

        // Restart mid-frame after 10 bits.
        n_before = n_out;
        drive_bit(1'b1, 1'b1);
        for (int i = 1; i < 10; i++) drive_bit(1'(i & 1), 1'b0);
        send_frame(32'h0000FFFF, 1'b0, 0);
        idle_cycles(3);
        check("restart_one_output", 64'(n_out - n_before), 64'd1);

        // Reset clears overrun; then back-to-back frames with no bubble.
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'd0);
        n_before = n_out;
        send_frame(32'hDEADBEEF, 1'b0, 0);
        send_frame(32'h0F0F00F1, 1'b1, 0);
        send_frame(32'h80000000, 1'b1, 0);
        idle_cycles(3);
        check("b2b_outputs", 64'(n_out - n_before), 64'd3);
        check("b2b_overrun", 64'(overrun), 64'd0);

        // Asynchronous reset while waiting for the parity bit.
        n_before = n_out;
        drive_bit(1'b1, 1'b1);
        for (int i = 1; i < DW; i++) drive_bit(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bit(1'b1, 1'b0);
        idle_cycles(2);
        check("rst_no_output", 64'(n_out - n_before), 64'd0);
        check("rst_idle_valid", 64'(out_valid), 64'd0);
        send_frame(32'h00000003, 1'b0, 0);

        // Random frames with random gaps between bits.
        for (int f = 0; f < 6; f++) begin
            idle_cycles($urandom_range(0, 3));
            send_frame(DW'($urandom), 1'($urandom_range(0, 1)), 2);
        end
        idle_cycles(3);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("final_overrun", 64'(overrun), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
